// File: rtl/wb_sram_responder_if.sv
// wb_if: Wishbone B4 bus bundle shared by a master and a slave.
//   ADDR_WIDTH : byte-address width of ADR
//   DATA_WIDTH : data width of DAT_W/DAT_R (SEL has DATA_WIDTH/8 bits)
// Modports: slave (responder side), master (initiator side).
interface wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   ADR;
    logic [DATA_WIDTH-1:0]   DAT_W;
    logic [DATA_WIDTH-1:0]   DAT_R;
    logic [DATA_WIDTH/8-1:0] SEL;
    logic                    WE;
    logic                    CYC;
    logic                    STB;
    logic [2:0]              CTI;
    logic [1:0]              BTE;
    logic                    ACK;
    logic                    ERR;
    logic                    TGD_R;
    logic                    TGA;
    logic                    TGC;
    logic                    TGD_W;

    modport slave (
        input  ADR, DAT_W, SEL, WE, CYC, STB, CTI, BTE, TGA, TGC, TGD_W,
        output DAT_R, ACK, ERR, TGD_R
    );

    modport master (
        output ADR, DAT_W, SEL, WE, CYC, STB, CTI, BTE, TGA, TGC, TGD_W,
        input  DAT_R, ACK, ERR, TGD_R
    );
endinterface

// File: rtl/wb_sram_responder.sv
// wb_sram_byte_lane: one byte lane of the SRAM. Write port plus a registered
// read port that can load a word or be forced to zero (error response).
//   clk, rst        : clock, async active-high reset (read register only)
//   we/wr_idx/wdata : byte write
//   rd_en/rd_idx    : load q from mem[rd_idx]
//   rd_clr          : force q to zero
//   q               : registered read byte
module wb_sram_byte_lane #(
    parameter int DEPTH_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] wr_idx,
    input  logic [7:0]            wdata,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [DEPTH_BITS-1:0] rd_idx,
    output logic [7:0]            q
);
    // Storage is intentionally not reset.
    logic [7:0] mem [2**DEPTH_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[wr_idx] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         q <= '0;
        else if (rd_clr) q <= '0;
        else if (rd_en)  q <= mem[rd_idx];
    end
endmodule

// wb_sram_responder: Wishbone B4 slave backed by a word-addressed SRAM with
// registered ACK/ERR. Addresses beyond the memory get ERR.
// Optional: define WB_SRAM_RESPONDER_BURST_EN for CTI/BTE burst support
// (constant / incrementing, linear or wrap-4/8/16, one beat per cycle when
// WAIT_STATES==0). Without it every beat is a classic cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   s   : wb_if.slave (ADR, DAT_W, DAT_R, SEL, WE, CYC, STB, CTI, BTE, ACK,
//         ERR; TGD_R tied 0; TGA/TGC/TGD_W ignored)
module wb_sram_responder #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter int WAIT_STATES   = 0
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  s
);
    localparam int NB  = WB_DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam int HI  = LSB + MEM_ADDR_BITS;
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef logic [WB_ADDR_WIDTH-1:0] addr_t;

`ifdef WB_SRAM_RESPONDER_BURST_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;
    localparam logic [2:0] CTI_CONST = 3'b001;
    localparam logic [2:0] CTI_INCR  = 3'b010;
    localparam addr_t      STEP      = addr_t'(NB);

    // Next burst address: only the bits inside the wrap mask change.
    function automatic addr_t next_addr(addr_t a, logic [2:0] cti, logic [1:0] bte);
        addr_t inc, mask;
        inc = (cti == CTI_CONST) ? a : a + STEP;
        case (bte)
            2'b01:   mask = addr_t'(3)  << LSB;
            2'b10:   mask = addr_t'(7)  << LSB;
            2'b11:   mask = addr_t'(15) << LSB;
            default: mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    logic [2:0] cti_r;
    logic [1:0] bte_r;
`else
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

    function automatic logic out_of_range(addr_t a);
        return (a >> HI) != '0;
    endfunction

    state_t            state;
    addr_t             addr_r;
    logic [3:0]        wcnt;
    logic              ack_r, err_r;
    logic [NB-1:0][7:0] dat_r;

    logic  term, wr_en, issue, issue_oor;
    addr_t issue_addr;

    assign term  = (ack_r | err_r) & s.CYC & s.STB;
    assign wr_en = ack_r & s.CYC & s.STB & s.WE;

    assign s.ACK   = ack_r & s.CYC & s.STB;
    assign s.ERR   = err_r & s.CYC & s.STB;
    assign s.DAT_R = dat_r;
    assign s.TGD_R = 1'b0;

    // "issue" marks the edge at which the next termination is armed: the
    // read for that beat is launched and ack_r/err_r are loaded together,
    // so data is already in dat_r when the ACK is seen.
    always_comb begin
        issue      = 1'b0;
        issue_addr = addr_r;
        if (s.CYC) begin
            case (state)
                IDLE: if (s.STB && WAIT_STATES == 0) begin
                    issue      = 1'b1;
                    issue_addr = s.ADR;
                end
                WAIT: if (wcnt == WAIT_LAST) issue = 1'b1;
`ifdef WB_SRAM_RESPONDER_BURST_EN
                RESP: if (term && !err_r && WAIT_STATES == 0 &&
                          (cti_r == CTI_CONST || cti_r == CTI_INCR)) begin
                    issue      = 1'b1;
                    issue_addr = next_addr(addr_r, cti_r, bte_r);
                end
                BURST: if (term && !err_r &&
                           (s.CTI == CTI_CONST || s.CTI == CTI_INCR)) begin
                    issue      = 1'b1;
                    issue_addr = next_addr(addr_r, s.CTI, s.BTE);
                end
`endif
                default: ;
            endcase
        end
    end

    assign issue_oor = out_of_range(issue_addr);

    for (genvar g = 0; g < NB; g++) begin : g_lane
        wb_sram_byte_lane #(.DEPTH_BITS(MEM_ADDR_BITS)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we     (wr_en & s.SEL[g]),
            .wr_idx (addr_r[LSB +: MEM_ADDR_BITS]),
            .wdata  (s.DAT_W[8*g +: 8]),
            .rd_en  (issue & ~issue_oor),
            .rd_clr (issue & issue_oor),
            .rd_idx (issue_addr[LSB +: MEM_ADDR_BITS]),
            .q      (dat_r[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_r <= '0;
            wcnt   <= '0;
            ack_r  <= 1'b0;
            err_r  <= 1'b0;
`ifdef WB_SRAM_RESPONDER_BURST_EN
            cti_r  <= '0;
            bte_r  <= '0;
`endif
        end else if (!s.CYC) begin
            state <= IDLE;
            wcnt  <= '0;
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (s.STB) begin
                    addr_r <= s.ADR;
`ifdef WB_SRAM_RESPONDER_BURST_EN
                    cti_r  <= s.CTI;
                    bte_r  <= s.BTE;
`endif
                    wcnt   <= '0;
                    state  <= (WAIT_STATES == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    if (wcnt == WAIT_LAST) state <= RESP;
                    else                   wcnt  <= wcnt + 4'd1;
                end
`ifdef WB_SRAM_RESPONDER_BURST_EN
                RESP:  if (term) state <= issue ? BURST : IDLE;
                BURST: if (term && !issue) state <= IDLE;
`else
                RESP:  if (term) state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
            if (issue) begin
                addr_r <= issue_addr;
                ack_r  <= ~issue_oor;
                err_r  <= issue_oor;
            end else if (term) begin
                ack_r <= 1'b0;
                err_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_sram_responder.sv
module tb_wb_sram_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_sel;
    logic [31:0] m_adr, m_dw;
    logic [3:0]  m_be;
    logic        m_we, m_cyc, m_stb;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    int n_chk = 0;
    int n_fail = 0;

`ifdef WB_SRAM_RESPONDER_BURST_EN
    localparam int NXT = 0;
`else
    localparam int NXT = 1;
`endif

    wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    assign bus0.ADR = m_adr;  assign bus1.ADR = m_adr;
    assign bus0.DAT_W = m_dw; assign bus1.DAT_W = m_dw;
    assign bus0.SEL = m_be;   assign bus1.SEL = m_be;
    assign bus0.WE = m_we;    assign bus1.WE = m_we;
    assign bus0.CTI = m_cti;  assign bus1.CTI = m_cti;
    assign bus0.BTE = m_bte;  assign bus1.BTE = m_bte;
    assign bus0.CYC = m_cyc & ~m_sel; assign bus1.CYC = m_cyc & m_sel;
    assign bus0.STB = m_stb & ~m_sel; assign bus1.STB = m_stb & m_sel;
    assign bus0.TGA = 1'b0;   assign bus1.TGA = 1'b0;
    assign bus0.TGC = 1'b0;   assign bus1.TGC = 1'b0;
    assign bus0.TGD_W = 1'b0; assign bus1.TGD_W = 1'b0;

    wb_sram_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .s(bus0));
    wb_sram_responder #(.WAIT_STATES(3)) dut1 (.clk(clk), .rst(rst), .s(bus1));

    logic        s_ack, s_err;
    logic [31:0] s_dat;
    assign s_ack = m_sel ? bus1.ACK : bus0.ACK;
    assign s_err = m_sel ? bus1.ERR : bus0.ERR;
    assign s_dat = m_sel ? bus1.DAT_R : bus0.DAT_R;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_cyc = 0; m_stb = 0; m_we = 0; m_be = 0;
        m_cti = 0; m_bte = 0; m_adr = 0; m_dw = 0;
    endtask

    // Present one beat and wait (bounded) for ACK/ERR; returns just after
    // the edge that consumes the termination, bus left driven.
    task automatic xfer(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dw, input logic [3:0] be,
                        input logic [2:0] cti, input logic [1:0] bte,
                        output int lat, output logic ack, output logic err,
                        output logic [31:0] dr);
        int n;
        n = 0;
        m_cyc = 1; m_stb = 1; m_we = we; m_adr = adr; m_dw = dw;
        m_be = be; m_cti = cti; m_bte = bte;
        lat = -1; ack = 0; err = 0; dr = '0;
        while (n < 16) begin
            @(negedge clk);
            n++;
            if (s_ack || s_err) begin
                lat = n - 1; ack = s_ack; err = s_err; dr = s_dat;
                break;
            end
        end
        if (lat < 0) chk({tag, "_timeout"}, {31'b0, s_ack | s_err}, 32'd1);
        tick();
    endtask

    task automatic wr(input string tag, input logic [31:0] adr, input logic [3:0] be,
                      input logic [31:0] dw, input int exp_lat);
        int lat; logic a, e; logic [31:0] d;
        xfer(tag, 1'b1, adr, dw, be, 3'b000, 2'b00, lat, a, e, d);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_ack"}, a, 1);
        idle();
        tick();
    endtask

    task automatic rd(input string tag, input logic [31:0] adr, input int exp_lat,
                      input logic [31:0] exp);
        int lat; logic a, e; logic [31:0] d;
        xfer(tag, 1'b0, adr, 0, 4'hF, 3'b000, 2'b00, lat, a, e, d);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_ack"}, a, 1);
        chk({tag, "_dat"}, d, exp);
        idle();
        tick();
    endtask

    initial begin
        int lat; logic a, e; logic [31:0] d;

        // Reset with a request pending: nothing may terminate.
        rst = 1; m_sel = 0; idle();
        m_cyc = 1; m_stb = 1; m_adr = 32'h0C;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", bus0.ACK, 0);
        chk("rst_err", bus0.ERR, 0);
        chk("rst_dat0", bus0.DAT_R, 0);
        chk("rst_dat1", bus1.DAT_R, 0);
        chk("rst_tgd", bus0.TGD_R, 0);
        idle();
        rst = 0;
        tick();

        // Classic write/read, then back-to-back classic reads.
        wr("w3", 32'h0C, 4'hF, 32'hDEADBEEF, 1);
        xfer("r3", 1'b0, 32'h0C, 0, 4'hF, 3'b000, 2'b00, lat, a, e, d);
        chk("r3_lat", lat, 1);
        chk("r3_dat", d, 32'hDEADBEEF);
        @(negedge clk);
        chk("c_gap", s_ack, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c_b2b_ack", s_ack, 1);
        chk("c_b2b_dat", s_dat, 32'hDEADBEEF);
        tick();
        idle();
        tick();

        // Byte-lane write.
        wr("w4", 32'h10, 4'hF, 32'h11223344, 1);
        wr("w4b", 32'h10, 4'b0010, 32'h0000AB00, 1);
        rd("r4", 32'h10, 1, 32'h1122AB44);

        // Same on the 3-wait-state instance.
        m_sel = 1;
        wr("ws_w4", 32'h10, 4'hF, 32'h11223344, 4);
        wr("ws_w4b", 32'h10, 4'b0010, 32'h0000AB00, 4);
        rd("ws_r4", 32'h10, 4, 32'h1122AB44);
        m_sel = 0;

        // Out-of-range: ERR, no write, DAT_R zero.
        wr("w0", 32'h0, 4'hF, 32'h0BADF00D, 1);
        xfer("oor_w", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 3'b000, 2'b00, lat, a, e, d);
        chk("oor_w_ack", a, 0);
        chk("oor_w_err", e, 1);
        idle(); tick();
        rd("r0", 32'h0, 1, 32'h0BADF00D);
        xfer("oor_r", 1'b0, 32'h1000, 0, 4'hF, 3'b000, 2'b00, lat, a, e, d);
        chk("oor_r_err", e, 1);
        chk("oor_r_dat", d, 0);
        idle(); tick();

        // Wrap-4 read burst from word 3.
        wr("p0", 32'h00, 4'hF, 32'h00000100, 1);
        wr("p1", 32'h04, 4'hF, 32'h00000101, 1);
        wr("p2", 32'h08, 4'hF, 32'h00000102, 1);
        for (int b = 0; b < 4; b++) begin
            xfer("wrap", 1'b0, ((3 + b) % 4) * 4, 0, 4'hF,
                 (b == 3) ? 3'b111 : 3'b010, 2'b01, lat, a, e, d);
            chk($sformatf("wrap%0d_lat", b), lat, (b == 0) ? 1 : NXT);
            chk($sformatf("wrap%0d_ack", b), a, 1);
            chk($sformatf("wrap%0d_dat", b), d, (b == 0) ? 32'hDEADBEEF : 32'h100 + b - 1);
        end
        m_cti = 3'b000;
        @(negedge clk);
        chk("wrap_end", s_ack, 0);
        idle();
        tick();

        // Linear burst running off the end of memory.
        wr("wlast", 32'hFFC, 4'hF, 32'hCAFEF00D, 1);
        xfer("lin0", 1'b0, 32'hFFC, 0, 4'hF, 3'b010, 2'b00, lat, a, e, d);
        chk("lin0_lat", lat, 1);
        chk("lin0_ack", a, 1);
        chk("lin0_dat", d, 32'hCAFEF00D);
        xfer("lin1", 1'b0, 32'h1000, 0, 4'hF, 3'b010, 2'b00, lat, a, e, d);
        chk("lin1_lat", lat, NXT);
        chk("lin1_ack", a, 0);
        chk("lin1_err", e, 1);
        chk("lin1_dat", d, 0);
        idle(); tick();

        // Incrementing write burst with STB and then CYC dropped.
        wr("p11", 32'h2C, 4'hF, 32'h5555AAAA, 1);
        xfer("wb0", 1'b1, 32'h20, 32'hA0A0A0A0, 4'hF, 3'b010, 2'b00, lat, a, e, d);
        chk("wb0_lat", lat, 1);
        xfer("wb1", 1'b1, 32'h24, 32'hA1A1A1A1, 4'hF, 3'b010, 2'b00, lat, a, e, d);
        chk("wb1_lat", lat, NXT);
        m_stb = 0;
        @(negedge clk);
        chk("stb_lo0", s_ack, 0);
        tick();
        @(negedge clk);
        chk("stb_lo1", s_ack, 0);
        tick();
        xfer("wb2", 1'b1, 32'h28, 32'hA2A2A2A2, 4'hF, 3'b010, 2'b00, lat, a, e, d);
        chk("wb2_lat", lat, NXT);
        chk("wb2_ack", a, 1);
        m_cyc = 0; m_stb = 1; m_we = 1; m_adr = 32'h2C; m_dw = 32'hDEAD0000;
        @(negedge clk);
        chk("cyc_lo", s_ack, 0);
        tick();
        idle(); tick();
        rd("rb0", 32'h20, 1, 32'hA0A0A0A0);
        rd("rb1", 32'h24, 1, 32'hA1A1A1A1);
        rd("rb2", 32'h28, 1, 32'hA2A2A2A2);
        rd("rb3", 32'h2C, 1, 32'h5555AAAA);

        // Asynchronous reset in the middle of a burst.
        xfer("rb", 1'b0, 32'h0C, 0, 4'hF, 3'b010, 2'b00, lat, a, e, d);
        chk("rb_dat", d, 32'hDEADBEEF);
        m_adr = 32'h10;
        rst = 1;
        #1;
        chk("arst_ack", bus0.ACK, 0);
        chk("arst_err", bus0.ERR, 0);
        chk("arst_dat", bus0.DAT_R, 0);
        idle();
        tick();
        rst = 0;
        tick();
        rd("post_rst", 32'h0C, 1, 32'hDEADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
